// File: rtl/wb_aperture_ctrl.sv
// Wishbone aperture controller: decodes bridge transfers to four slave
// regions, sequences the slave cycle select, returns ACK/data, and
// terminates unmapped or unanswered transfers with a default acknowledge.
// Timeouts are logged in sticky status outputs.
//
// Ports:
//   WBs_CLK_i / WBs_RST_i   clock, asynchronous active-high reset
//   WBs_ADR_i, WBs_CYC_i,
//   WBs_STB_i               transfer request from the bridge
//   WBs_DAT_o, WBs_ACK_o    registered read data / acknowledge to bridge
//   WBs_CYC_slv_o           one-hot slave cycle selects
//   WBs_ACK_slv_i,
//   WBs_DAT_slv_i           slave acknowledges and packed read data
//   Tmo_Flag_o, Tmo_Cnt_o,
//   Tmo_Adr_o               sticky flag, saturating count, first address
//   Tmo_Clr_i               clears flag and count (address kept)
//   Tmo_Irq_o               timeout pulse, present only when
//                           WB_APERTURE_CTRL_TMO_IRQ_EN is defined
module wb_aperture_ctrl #(
  parameter int ADDRWIDTH      = 10,
  parameter int DATAWIDTH      = 32,
  parameter int NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES-1:0] SLAVE_EN_MASK = 4'b1111,
  parameter int TMO_CNTR_WIDTH = 4,
  parameter int TMO_CYCLES     = 12,
  parameter logic [DATAWIDTH-1:0] DEF_REG_VALUE = 32'hDEF_FAB_AC
) (
  input  logic                           WBs_CLK_i,
  input  logic                           WBs_RST_i,
  input  logic [ADDRWIDTH-1:0]           WBs_ADR_i,
  input  logic                           WBs_CYC_i,
  input  logic                           WBs_STB_i,
  output logic [DATAWIDTH-1:0]           WBs_DAT_o,
  output logic                           WBs_ACK_o,
  output logic [NUM_SLAVES-1:0]          WBs_CYC_slv_o,
  input  logic [NUM_SLAVES-1:0]          WBs_ACK_slv_i,
  input  logic [NUM_SLAVES*DATAWIDTH-1:0] WBs_DAT_slv_i,
  output logic                           Tmo_Flag_o,
  output logic [7:0]                     Tmo_Cnt_o,
  output logic [ADDRWIDTH-1:0]           Tmo_Adr_o,
  input  logic                           Tmo_Clr_i
`ifdef WB_APERTURE_CTRL_TMO_IRQ_EN
  ,
  output logic                           Tmo_Irq_o
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [NUM_SLAVES-1:0] ONE_HOT0 = 1;
  localparam logic [TMO_CNTR_WIDTH-1:0] TMO_LOAD =
    TMO_CNTR_WIDTH'(TMO_CYCLES);
  localparam logic [TMO_CNTR_WIDTH-1:0] TMO_LAST =
    TMO_CNTR_WIDTH'(1);

  state_t                      state_q, state_d;
  logic [1:0]                  sel_q, sel_d;
  logic [ADDRWIDTH-1:0]        adr_q, adr_d;
  logic [TMO_CNTR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                        ack_q, ack_d;
  logic [DATAWIDTH-1:0]        dat_q, dat_d;
  logic [NUM_SLAVES-1:0]       cyc_slv_q, cyc_slv_d;
  logic                        tmo_flag_q, tmo_flag_d;
  logic [7:0]                  tmo_cnt_q, tmo_cnt_d;
  logic [ADDRWIDTH-1:0]        tmo_adr_q, tmo_adr_d;
  logic                        tmo_evt;
  logic [1:0]                  req_idx;
  logic [DATAWIDTH-1:0]        slv_rdat;

  assign req_idx  = WBs_ADR_i[ADDRWIDTH-1 -: 2];
  assign slv_rdat = WBs_DAT_slv_i[DATAWIDTH*int'(sel_q) +: DATAWIDTH];

  // Outputs are registered from next-state values so the select
  // and acknowledge appear the cycle after the deciding condition.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    dat_d     = dat_q;
    cyc_slv_d = '0;
    tmo_evt   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (WBs_CYC_i && WBs_STB_i) begin
          sel_d = req_idx;
          adr_d = WBs_ADR_i;
          if (SLAVE_EN_MASK[req_idx]) begin
            state_d   = ACTIVE;
            cnt_d     = TMO_LOAD;
            cyc_slv_d = ONE_HOT0 << req_idx;
          end else begin
            state_d = DONE;
            ack_d   = 1'b1;
            dat_d   = DEF_REG_VALUE;
          end
        end
      end
      ACTIVE: begin
        if (!WBs_CYC_i) begin
          state_d = IDLE;
        end else if (WBs_ACK_slv_i[sel_q]) begin
          // A slave ACK on the last counted cycle still wins.
          state_d = DONE;
          ack_d   = 1'b1;
          dat_d   = slv_rdat;
        end else if (cnt_q == TMO_LAST) begin
          state_d = DONE;
          ack_d   = 1'b1;
          dat_d   = DEF_REG_VALUE;
          tmo_evt = 1'b1;
        end else begin
          cnt_d     = cnt_q - 1'b1;
          cyc_slv_d = ONE_HOT0 << sel_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A timeout coinciding with a clear restarts the log from this event.
  always_comb begin
    tmo_flag_d = tmo_flag_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_adr_d  = tmo_adr_q;
    if (tmo_evt) begin
      tmo_flag_d = 1'b1;
      if (Tmo_Clr_i) begin
        tmo_cnt_d = 8'd1;
      end else if (tmo_cnt_q != 8'hFF) begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
      end
      if (!tmo_flag_q || Tmo_Clr_i) begin
        tmo_adr_d = adr_q;
      end
    end else if (Tmo_Clr_i) begin
      tmo_flag_d = 1'b0;
      tmo_cnt_d  = 8'd0;
    end
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      adr_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      cyc_slv_q  <= '0;
      tmo_flag_q <= 1'b0;
      tmo_cnt_q  <= '0;
      tmo_adr_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      cyc_slv_q  <= cyc_slv_d;
      tmo_flag_q <= tmo_flag_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_adr_q  <= tmo_adr_d;
    end
  end

  assign WBs_ACK_o     = ack_q;
  assign WBs_DAT_o     = dat_q;
  assign WBs_CYC_slv_o = cyc_slv_q;
  assign Tmo_Flag_o    = tmo_flag_q;
  assign Tmo_Cnt_o     = tmo_cnt_q;
  assign Tmo_Adr_o     = tmo_adr_q;

`ifdef WB_APERTURE_CTRL_TMO_IRQ_EN
  logic irq_q;

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= tmo_evt;
    end
  end

  assign Tmo_Irq_o = irq_q;
`endif

endmodule

// File: tb/tb_wb_aperture_ctrl.sv
// Directed testbench for wb_aperture_ctrl (regions 0..2 populated,
// region 3 unmapped). Inputs change and outputs are sampled at negedge.
module tb_wb_aperture_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam logic [DW-1:0] DEF = 32'hDEF_FAB_AC;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     adr;
  logic              cyc;
  logic              stb;
  logic [DW-1:0]     dat_o;
  logic              ack_o;
  logic [NS-1:0]     cyc_slv;
  logic [NS-1:0]     ack_slv;
  logic [NS*DW-1:0]  dat_slv;
  logic              flag;
  logic [7:0]        cnt;
  logic [AW-1:0]     tadr;
  logic              clr;
`ifdef WB_APERTURE_CTRL_TMO_IRQ_EN
  logic              irq;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wb_aperture_ctrl #(
    .SLAVE_EN_MASK(4'b0111)
  ) dut (
    .WBs_CLK_i    (clk),
    .WBs_RST_i    (rst),
    .WBs_ADR_i    (adr),
    .WBs_CYC_i    (cyc),
    .WBs_STB_i    (stb),
    .WBs_DAT_o    (dat_o),
    .WBs_ACK_o    (ack_o),
    .WBs_CYC_slv_o(cyc_slv),
    .WBs_ACK_slv_i(ack_slv),
    .WBs_DAT_slv_i(dat_slv),
    .Tmo_Flag_o   (flag),
    .Tmo_Cnt_o    (cnt),
    .Tmo_Adr_o    (tadr),
    .Tmo_Clr_i    (clr)
`ifdef WB_APERTURE_CTRL_TMO_IRQ_EN
    ,
    .Tmo_Irq_o    (irq)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full unanswered transfer; leaves the bench in the ACK cycle.
  task automatic tmo_xfer(input logic [AW-1:0] a, input logic c);
    adr = a;
    cyc = 1'b1;
    stb = 1'b1;
    step(12);
    clr = c;
    step(1);
    clr = 1'b0;
    cyc = 1'b0;
    stb = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    adr     = '0;
    cyc     = 1'b0;
    stb     = 1'b0;
    ack_slv = '0;
    clr     = 1'b0;
    dat_slv = '0;
    dat_slv[0*DW +: DW] = 32'h5555_0000;
    dat_slv[1*DW +: DW] = 32'hAAAA_AAAA;
    dat_slv[2*DW +: DW] = 32'h1234_5678;
    dat_slv[3*DW +: DW] = 32'h3333_3333;
    step(2);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_sel", 32'(cyc_slv), 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_tadr", 32'(tadr), 32'd0);
    rst = 1'b0;
    step(1);

    // Region 2 read, slave answers in cycle 3.
    adr = 10'h210;
    cyc = 1'b1;
    stb = 1'b1;
    step(1);
    chk("r2_sel_c1", 32'(cyc_slv), 32'h4);
    chk("r2_ack_c1", 32'(ack_o), 32'd0);
    step(2);
    chk("r2_ack_c3", 32'(ack_o), 32'd0);
    ack_slv = 4'b0100;
    step(1);
    chk("r2_ack_c4", 32'(ack_o), 32'd1);
    chk("r2_dat", dat_o, 32'h1234_5678);
    chk("r2_sel_c4", 32'(cyc_slv), 32'd0);
    chk("r2_flag", 32'(flag), 32'd0);
    ack_slv = '0;
    cyc = 1'b0;
    stb = 1'b0;
    step(1);
    chk("r2_ack_c5", 32'(ack_o), 32'd0);

    // Region 1 read with no answer: timeout.
    adr = 10'h104;
    cyc = 1'b1;
    stb = 1'b1;
    step(12);
    chk("t1_ack_c12", 32'(ack_o), 32'd0);
    chk("t1_sel_c12", 32'(cyc_slv), 32'h2);
    chk("t1_flag_c12", 32'(flag), 32'd0);
    step(1);
    chk("t1_ack_c13", 32'(ack_o), 32'd1);
    chk("t1_dat", dat_o, DEF);
    chk("t1_flag", 32'(flag), 32'd1);
    chk("t1_cnt", 32'(cnt), 32'd1);
    chk("t1_tadr", 32'(tadr), 32'h104);
    chk("t1_sel_c13", 32'(cyc_slv), 32'd0);
`ifdef WB_APERTURE_CTRL_TMO_IRQ_EN
    chk("t1_irq", 32'(irq), 32'd1);
`endif
    cyc = 1'b0;
    stb = 1'b0;
    step(1);
    chk("t1_ack_c14", 32'(ack_o), 32'd0);
`ifdef WB_APERTURE_CTRL_TMO_IRQ_EN
    chk("t1_irq_c14", 32'(irq), 32'd0);
`endif

    tmo_xfer(10'h1F0, 1'b0);
    chk("t2_ack", 32'(ack_o), 32'd1);
    chk("t2_cnt", 32'(cnt), 32'd2);
    chk("t2_tadr", 32'(tadr), 32'h104);
    step(1);

    // Region 0: stray region-1 ACK throughout, real ACK on last cycle.
    adr = 10'h004;
    cyc = 1'b1;
    stb = 1'b1;
    step(1);
    chk("lc_sel_c1", 32'(cyc_slv), 32'h1);
    ack_slv = 4'b0010;
    step(1);
    chk("lc_stray_c2", 32'(ack_o), 32'd0);
    step(10);
    chk("lc_stray_c12", 32'(ack_o), 32'd0);
    ack_slv = 4'b0011;
    step(1);
    chk("lc_ack_c13", 32'(ack_o), 32'd1);
    chk("lc_dat", dat_o, 32'h5555_0000);
    chk("lc_cnt", 32'(cnt), 32'd2);
`ifdef WB_APERTURE_CTRL_TMO_IRQ_EN
    chk("lc_irq", 32'(irq), 32'd0);
`endif
    ack_slv = '0;
    cyc = 1'b0;
    stb = 1'b0;
    step(1);

    // Unmapped region 3.
    adr = 10'h3C0;
    cyc = 1'b1;
    stb = 1'b1;
    step(1);
    chk("um_ack", 32'(ack_o), 32'd1);
    chk("um_dat", dat_o, DEF);
    chk("um_sel", 32'(cyc_slv), 32'd0);
    chk("um_cnt", 32'(cnt), 32'd2);
`ifdef WB_APERTURE_CTRL_TMO_IRQ_EN
    chk("um_irq", 32'(irq), 32'd0);
`endif
    cyc = 1'b0;
    stb = 1'b0;
    step(1);
    chk("um_ack_c2", 32'(ack_o), 32'd0);

    // Grow count to 5, then timeout with a simultaneous clear.
    for (int i = 0; i < 3; i++) begin
      tmo_xfer(10'h1F4, 1'b0);
      step(1);
    end
    chk("c5_cnt", 32'(cnt), 32'd5);
    tmo_xfer(10'h0A8, 1'b1);
    chk("clrt_flag", 32'(flag), 32'd1);
    chk("clrt_cnt", 32'(cnt), 32'd1);
    chk("clrt_tadr", 32'(tadr), 32'h0A8);
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_flag", 32'(flag), 32'd0);
    chk("clr_cnt", 32'(cnt), 32'd0);
    chk("clr_tadr", 32'(tadr), 32'h0A8);

    // Abort: CYC dropped while ACTIVE.
    adr = 10'h200;
    cyc = 1'b1;
    stb = 1'b1;
    step(1);
    chk("ab_sel_c1", 32'(cyc_slv), 32'h4);
    step(1);
    cyc = 1'b0;
    stb = 1'b0;
    step(1);
    chk("ab_sel_c3", 32'(cyc_slv), 32'd0);
    chk("ab_ack_c3", 32'(ack_o), 32'd0);
    step(1);
    chk("ab_ack_c4", 32'(ack_o), 32'd0);
    chk("ab_flag", 32'(flag), 32'd0);

    // Reset while ACTIVE.
    adr = 10'h010;
    cyc = 1'b1;
    stb = 1'b1;
    step(1);
    chk("mr_sel_c1", 32'(cyc_slv), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mr_sel", 32'(cyc_slv), 32'd0);
    chk("mr_ack", 32'(ack_o), 32'd0);
    chk("mr_dat", dat_o, 32'd0);
    chk("mr_tadr", 32'(tadr), 32'd0);
    chk("mr_cnt", 32'(cnt), 32'd0);
    cyc = 1'b0;
    stb = 1'b0;
    step(1);
    rst = 1'b0;
    step(2);
    chk("mr_ack_after", 32'(ack_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
